// File: rtl/flag_sync_rx.sv
// Receive side of toggle-encoded flag crossings: per-channel synchroniser,
// event pulse regeneration and a saturating pending counter (or level pass-through).
module flag_sync_rx #(
  parameter int                  CHANNELS   = 4,
  parameter int                  STAGES     = 2,
  parameter int                  CNT_W      = 4,
  parameter logic [CHANNELS-1:0] LEVEL_MASK = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       toggle_in,
  input  logic [CHANNELS-1:0]       pop,
  input  logic [CHANNELS-1:0]       ovf_clear,
  output logic [CHANNELS-1:0]       level_out,
  output logic [CHANNELS-1:0]       pulse_out,
  output logic [CHANNELS-1:0]       pending_valid,
  output logic [CHANNELS*CNT_W-1:0] pending_count,
  output logic [CHANNELS-1:0]       overflow
);

  localparam int                WARM_W   = $clog2(STAGES + 2);
  localparam logic [WARM_W-1:0] WARM_END = WARM_W'(STAGES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [CHANNELS-1:0][STAGES:0]  syncChain;
  logic [CHANNELS-1:0][CNT_W-1:0] count;
  logic [WARM_W-1:0]              warmCnt;
  logic                           warmDone;
  logic [CHANNELS-1:0]            rawEvent;
  logic [CHANNELS-1:0]            chanEvent;
  logic [CHANNELS-1:0]            effPop;
  logic [CHANNELS-1:0]            ovfSet;
  logic [CHANNELS-1:0]            ovfClr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syncChain <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        syncChain[i] <= {syncChain[i][STAGES-1:0], toggle_in[i]};
      end
    end
  end

  // Chain flops start at 0, so a line already high at release looks like an
  // edge travelling down the chain; hold events off until it has flushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warmCnt <= '0;
    end else if (!warmDone) begin
      warmCnt <= warmCnt + WARM_W'(1);
    end
  end

  assign warmDone = (warmCnt == WARM_END);

  always_comb begin
    level_out     = '0;
    rawEvent      = '0;
    chanEvent     = '0;
    effPop        = '0;
    ovfSet        = '0;
    ovfClr        = '0;
    pending_valid = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      level_out[i]     = syncChain[i][STAGES-1];
      rawEvent[i]      = syncChain[i][STAGES-1] ^ syncChain[i][STAGES];
      chanEvent[i]     = rawEvent[i] & warmDone & ~LEVEL_MASK[i];
      effPop[i]        = pop[i] & (count[i] != '0) & ~LEVEL_MASK[i];
      ovfSet[i]        = chanEvent[i] & ~effPop[i] & (count[i] == CNT_MAX);
      ovfClr[i]        = ovf_clear[i] & ~LEVEL_MASK[i];
      pending_valid[i] = (count[i] != '0);
    end
  end

  // A lost event at saturation outranks a clear arriving on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_out <= '0;
      count     <= '0;
      overflow  <= '0;
    end else begin
      pulse_out <= chanEvent;
      for (int i = 0; i < CHANNELS; i++) begin
        if (chanEvent[i] && !effPop[i] && (count[i] != CNT_MAX)) begin
          count[i] <= count[i] + CNT_W'(1);
        end else if (effPop[i] && !chanEvent[i]) begin
          count[i] <= count[i] - CNT_W'(1);
        end
        if (ovfSet[i]) begin
          overflow[i] <= 1'b1;
        end else if (ovfClr[i]) begin
          overflow[i] <= 1'b0;
        end
      end
    end
  end

  assign pending_count = count;

endmodule
